// File: rtl/pipelined_addsub.sv
// pipelined_addsub: carry-chunked pipelined adder/subtractor with valid/ready flow control
module pipelined_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CHUNK = WIDTH / STAGES;
    localparam int L = STAGES - 1;
    logic             r_v  [STAGES];
    logic [WIDTH-1:0] r_a  [STAGES];
    logic [WIDTH-1:0] r_b  [STAGES];
    logic [WIDTH-1:0] r_s  [STAGES];
    logic             r_c  [STAGES];
    logic             r_cm;
    logic             w_rdy[STAGES+1];
    logic             w_vi [STAGES];
    logic [WIDTH-1:0] w_ai [STAGES];
    logic [WIDTH-1:0] w_bi [STAGES];
    logic [WIDTH-1:0] w_si [STAGES];
    logic [WIDTH-1:0] w_sn [STAGES];
    logic             w_ci [STAGES];
    logic             w_cn [STAGES];
    logic [CHUNK:0]   w_t;
    logic             w_cm;
    // Ready ripples back from the consumer; an empty stage is always ready
    always_comb begin
        w_rdy[STAGES] = out_ready;
        for (int k = L; k >= 0; k--) w_rdy[k] = !r_v[k] || w_rdy[k+1];
    end
    // Stage inputs, per-stage chunk addition and carry into the MSB
    always_comb begin
        w_t      = '0;
        w_vi[0]  = in_valid;
        w_ai[0]  = a;
        w_bi[0]  = sub ? ~b : b;
        w_ci[0]  = sub | cin;
        w_si[0]  = '0;
        for (int k = 1; k < STAGES; k++) begin
            w_vi[k] = r_v[k-1];
            w_ai[k] = r_a[k-1];
            w_bi[k] = r_b[k-1];
            w_ci[k] = r_c[k-1];
            w_si[k] = r_s[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            w_t = {1'b0, w_ai[k][k*CHUNK +: CHUNK]} + {1'b0, w_bi[k][k*CHUNK +: CHUNK]}
                + (CHUNK+1)'(w_ci[k]);
            w_sn[k] = w_si[k];
            w_sn[k][k*CHUNK +: CHUNK] = w_t[CHUNK-1:0];
            w_cn[k] = w_t[CHUNK];
        end
        w_cm = w_ai[L][WIDTH-1] ^ w_bi[L][WIDTH-1] ^ w_sn[L][WIDTH-1];
    end
    // Each ready stage takes its upstream; data only loads with a valid transaction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                r_v[k] <= 1'b0;
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
                r_c[k] <= 1'b0;
            end
            r_cm <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_rdy[k]) begin
                    r_v[k] <= w_vi[k];
                    if (w_vi[k]) begin
                        r_a[k] <= w_ai[k];
                        r_b[k] <= w_bi[k];
                        r_s[k] <= w_sn[k];
                        r_c[k] <= w_cn[k];
                    end
                end
            end
            if (w_rdy[L] && w_vi[L]) r_cm <= w_cm;
        end
    end
    assign in_ready  = w_rdy[0];
    assign out_valid = r_v[L];
    assign sum       = r_s[L];
    assign cout      = r_c[L];
    assign ovf       = r_cm ^ r_c[L];
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: directed and randomised checks of the pipelined adder/subtractor
module tb_pipelined_addsub;
    logic        clk = 1'b0;
    logic        rst;
    logic        iv, ir, ov, ordy, ci, sb, co, of;
    logic [15:0] a, b, s;
    logic        iv1, ir1, ov1, or1, ci1, sb1, co1, of1;
    logic [3:0]  a1, b1, s1;
    int          checks = 0, failures = 0;
    int          sent, recv, stall;
    logic        started, pstall, pend;
    logic [17:0] prev;
    logic [17:0] q[$];

    always #5 clk = ~clk;

    pipelined_addsub u0 (
        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .a(a), .b(b), .cin(ci), .sub(sb),
        .out_valid(ov), .out_ready(ordy), .sum(s), .cout(co), .ovf(of)
    );

    pipelined_addsub #(.WIDTH(4), .STAGES(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .cin(ci1), .sub(sb1),
        .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(co1), .ovf(of1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference result {ovf, cout, sum} using the sign-based overflow rule
    function automatic logic [17:0] mdl(input logic [15:0] x, input logic [15:0] y,
                                        input logic c, input logic m);
        logic [15:0] e;
        logic [16:0] r;
        logic        v;
        e = m ? ~y : y;
        r = {1'b0, x} + {1'b0, e} + 17'(m | c);
        v = (x[15] == e[15]) && (r[15] != x[15]);
        return {v, r[16], r[15:0]};
    endfunction

    function automatic logic [31:0] popq();
        return (q.size() != 0) ? 32'(q.pop_front()) : 32'hDEAD_BEEF;
    endfunction

    initial begin
        rst = 1'b1;
        iv = 0; a = 0; b = 0; ci = 0; sb = 0; ordy = 1;
        iv1 = 0; a1 = 0; b1 = 0; ci1 = 0; sb1 = 0; or1 = 1;
        @(negedge clk);
        chk("rst_ov", ov, 0);
        chk("rst_res", {of, co, s}, 0);
        chk("rst_ov1", ov1, 0);
        rst = 1'b0;
        #1;
        chk("idle_ir", ir, 1);
        chk("idle_ov", ov, 0);

        // Legacy 4-bit, single stage: 1101 + 0101
        a1 = 4'b1101; b1 = 4'b0101; iv1 = 1;
        tick();
        a1 = 4'b0011; b1 = 4'b0101; sb1 = 1;
        #1;
        chk("w4_ov", ov1, 1);
        chk("w4_add", {of1, co1, s1}, {1'b0, 1'b1, 4'b0010});
        tick();
        iv1 = 0;
        #1;
        chk("w4_sub", {of1, co1, s1}, {1'b0, 1'b0, 4'b1110});
        tick();
        #1;
        chk("w4_nodup", ov1, 0);

        // Latency and back-to-back adds
        a = 16'hFFFF; b = 16'h0001; ci = 1; iv = 1;
        #1;
        chk("lat_ir", ir, 1);
        tick();
        a = 16'h7FFF; b = 16'h0001; ci = 0;
        #1;
        chk("lat_e1", ov, 0);
        tick();
        iv = 0;
        #1;
        chk("lat_e2", ov, 0);
        tick();
        #1;
        chk("lat_e3", ov, 0);
        tick();
        #1;
        chk("lat_e4_ov", ov, 1);
        chk("add1", {of, co, s}, {1'b0, 1'b1, 16'h0001});
        tick();
        #1;
        chk("add2_ov", ov, 1);
        chk("add2", {of, co, s}, {1'b1, 1'b0, 16'h8000});
        tick();
        #1;
        chk("add_nodup", ov, 0);

        // Subtract mode, cin ignored
        a = 16'h0005; b = 16'h0007; sb = 1; ci = 1; iv = 1;
        tick();
        a = 16'h8000; b = 16'h0001; ci = 0;
        tick();
        iv = 0; sb = 0;
        tick();
        tick();
        #1;
        chk("sub1", {of, co, s}, {1'b0, 1'b0, 16'hFFFE});
        tick();
        #1;
        chk("sub2", {of, co, s}, {1'b1, 1'b1, 16'h7FFF});
        tick();

        // Backpressure with 6 streaming transactions
        sent = 0; recv = 0; stall = 0; started = 0; pstall = 0; q.delete();
        a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom); sb = 1'($urandom); iv = 1;
        for (int c = 0; c < 40 && recv < 6; c++) begin
            if (ov && !started) begin
                started = 1;
                stall = 3;
            end
            ordy = (stall == 0);
            #1;
            if (pstall) begin
                chk("bp_hold_v", ov, 1);
                chk("bp_hold_d", {of, co, s}, prev);
            end
            if (!ordy) chk("bp_inrdy", ir, 32'((sent - recv) < 4));
            pstall = ov && !ordy;
            prev = {of, co, s};
            if (ov && ordy) begin
                chk("bp_data", {of, co, s}, popq());
                recv++;
            end
            pend = iv && !ir;
            if (iv && ir) begin
                q.push_back(mdl(a, b, ci, sb));
                sent++;
            end
            tick();
            if (stall > 0) stall--;
            if (!pend) begin
                a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom); sb = 1'($urandom);
                iv = (sent < 6);
            end
        end
        iv = 0; ordy = 1;
        chk("bp_count", recv, 6);
        chk("bp_stalled", started, 1);

        // Reset with three transactions in flight
        q.delete();
        sb = 0; ci = 0; iv = 1;
        for (int i = 0; i < 3; i++) begin
            a = 16'($urandom); b = 16'($urandom);
            tick();
        end
        iv = 0;
        rst = 1;
        #1;
        chk("mid_rst_ov", ov, 0);
        chk("mid_rst_sum", s, 0);
        tick();
        rst = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("post_rst_idle", ov, 0);
            tick();
        end
        a = 16'h1234; b = 16'h1111; iv = 1;
        tick();
        iv = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("post_rst_lat", ov, 0);
            tick();
        end
        #1;
        chk("post_rst_ov", ov, 1);
        chk("post_rst_res", {of, co, s}, {1'b0, 1'b0, 16'h2345});
        tick();

        // Random soak with random valid and ready
        sent = 0; recv = 0; pend = 0; q.delete();
        for (int c = 0; c < 4000; c++) begin
            if (!pend) begin
                iv = 1'($urandom);
                a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom); sb = 1'($urandom);
            end
            ordy = ($urandom_range(3) != 0);
            #1;
            if (ov && ordy) begin
                chk("soak", {of, co, s}, popq());
                recv++;
            end
            if (iv && ir) begin
                q.push_back(mdl(a, b, ci, sb));
                sent++;
            end
            pend = iv && !ir;
            tick();
        end
        iv = 0; ordy = 1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (ov) begin
                chk("soak_drain", {of, co, s}, popq());
                recv++;
            end
            tick();
        end
        chk("soak_count", recv, sent);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
